sort_floats_seq: RTL and testbench
==================================

// Module: sort_floats_seq
// PURPOSE
//  Sequential sorter for N FLEN-bit floats, ascending. Successor to the fixed 2/3-input combinational sorters.
//  Loads a vector in one upstream handshake, then bubble-sorts it in place with one shared f_less_or_equal.
//  Returns the sorted vector on a valid/ready downstream port. Sits between float producer and consumer stages.
// PARAMETERS
//  N           4   number of floats per vector; legal N >= 2
//  EARLY_EXIT  1   1: finish after the first pass with no swap; 0: always run N-1 full passes
//  (FLEN comes from the shared float package; it is not a parameter of this block)
// PORTS
//  clk         in   1            clock; all state updates on rising edge
//  rst         in   1            asynchronous, active-high reset
//  up_valid    in   1            upstream vector valid
//  up_ready    out  1            block can accept a vector
//  up_data     in   N*FLEN       [0:N-1][FLEN-1:0] unsorted vector
//  down_valid  out  1            result valid
//  down_ready  in   1            consumer accepts result
//  down_data   out  N*FLEN       [0:N-1][FLEN-1:0] result; element 0 is smallest
//  down_err    out  1            comparator flagged error; sort aborted
// BEHAVIOUR
//  Reset (async, any state) -> IDLE, buffer=0, counters=0.
//    Outputs during reset: up_ready=0, down_valid=0, down_err=0, down_data=0.
//  States:
//   IDLE: up_ready=1. up_valid&&up_ready loads buffer<=up_data, j<=0, pass<=0, swapped<=0 -> SORT.
//   SORT: up_ready=0. One comparison per cycle: a=buf[j], b=buf[j+1].
//    - err=1: no swap; down_err<=1 -> DONE immediately.
//    - else if !(a<=b): swap buf[j]/buf[j+1], swapped<=1. Equal values are never swapped (stable).
//    - j=0..N-2. At j=N-2 (end of pass): if pass==N-2, or (EARLY_EXIT && no swap this pass incl. this cycle) -> DONE.
//      Otherwise pass++, j<=0, swapped<=0.
//   DONE: down_valid=1. down_data=buffer, down_err held stable until down_valid&&down_ready -> IDLE.
//    On leaving DONE: down_err<=0. up_ready is 1 in the following cycle (no same-cycle reload).
//  Latency: load edge at cycle 0; SORT occupies cycles 1..C; down_valid first high at cycle C+1.
//   EARLY_EXIT=0: C=(N-1)^2 always.
//   EARLY_EXIT=1: C=(N-1)*P, where P = passes executed, 1 <= P <= N-1.
//   Error: C = index of the erroring compare cycle.
//  Throughput: one vector in flight; up_ready=0 in SORT/DONE.
//  Counters: j is $clog2(N-1)+1 bits, pass the same; no wrap beyond N-2.
//  Comparator: f_less_or_equal is purely combinational; its res/err are sampled only in SORT.
// STRUCTURE
//  Shared package: FLEN (existing), float_t typedef, state enum {IDLE,SORT,DONE}.
//  Sub-modules: one instance of the existing f_less_or_equal; FSM, buffer and counters live in this file.
//  Compare operands: muxes off buf[j] and buf[j+1].
// TESTING (N=4, EARLY_EXIT=1 unless noted; values are IEEE singles)
//  1 Already sorted {1.0,2.0,3.0,4.0}.
//    -> down_valid at cycle 4; data unchanged; err=0.
//  2 Reversed {4.0,3.0,2.0,1.0}.
//    -> down_valid at cycle 10 (3 passes); data {1,2,3,4}.
//  3 EARLY_EXIT=0, input {1,2,3,4}.
//    -> down_valid at cycle 10; data {1,2,3,4}.
//  4 Duplicates and negatives {2.0,-1.5,2.0,0.0}.
//    -> data {-1.5,0.0,2.0,2.0}; err=0.
//  5 NaN in element 1 {1.0,NaN,0.5,3.0}.
//    -> down_valid at cycle 2; down_err=1; data = input unchanged.
//  6 Backpressure: hold down_ready=0 for 5 cycles in DONE.
//    -> down_data, down_err stable; up_ready=0.
//    -> Release down_ready: IDLE next cycle; the next vector sorts correctly with err=0.
//  7 Assert rst during SORT.
//    -> All outputs 0 immediately.
//    -> After release, IDLE: up_ready=1; a new vector sorts correctly.

Source files
------------

// File: rtl/sort_floats_seq_pkg.sv
// Shared definitions for the sequential float sorter.
// This package holds the float width, the float type, the sorter FSM states
// and small helpers for classifying IEEE-754 single-precision values.
package sort_floats_seq_pkg;

    localparam int FLEN  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef logic [FLEN-1:0] float_t;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    // A value is NaN when the exponent is all ones and the mantissa is non-zero.
    function automatic logic is_nan(input float_t x);
        return (&x[FLEN-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    // A value is zero when everything except the sign is zero.
    // This makes +0 and -0 compare as equal.
    function automatic logic is_zero(input float_t x);
        return ~|x[FLEN-2:0];
    endfunction

endpackage

// File: rtl/sort_floats_seq_f_less_or_equal.sv
// Combinational IEEE-754 single-precision a <= b comparator.
// If either operand is NaN, err is raised and res is forced low.
// Signed zeros are treated as equal.
module f_less_or_equal
    import sort_floats_seq_pkg::*;
(
    input  float_t a,
    input  float_t b,
    output logic   res,
    output logic   err
);

    logic nan_a;
    logic nan_b;

    assign nan_a = is_nan(a);
    assign nan_b = is_nan(b);

    // Handle zeros and mixed signs first, then compare magnitudes.
    // For negative values the magnitude order is reversed.
    always_comb begin
        err = nan_a | nan_b;
        res = 1'b0;
        if (!err) begin
            if (is_zero(a) && is_zero(b)) begin
                res = 1'b1;
            end else if (a[FLEN-1] != b[FLEN-1]) begin
                res = a[FLEN-1];
            end else if (!a[FLEN-1]) begin
                res = (a[FLEN-2:0] <= b[FLEN-2:0]);
            end else begin
                res = (a[FLEN-2:0] >= b[FLEN-2:0]);
            end
        end
    end

endmodule

// File: rtl/sort_floats_seq.sv
// Sequential ascending sorter for N floats.
// A whole vector is loaded in a single handshake. It is then bubble-sorted in
// place, using one shared comparator and one compare per cycle. The result is
// presented on a valid/ready port. A NaN aborts the sort and raises down_err.
module sort_floats_seq
    import sort_floats_seq_pkg::*;
#(
    parameter int N          = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [0:N-1][FLEN-1:0]     up_data,
    output logic                       down_valid,
    input  logic                       down_ready,
    output logic [0:N-1][FLEN-1:0]     down_data,
    output logic                       down_err
);

    localparam int            CW   = $clog2(N-1) + 1;
    localparam logic [CW-1:0] LAST = CW'(N-2);

    state_t                   state;
    logic [0:N-1][FLEN-1:0]   data_buf;
    logic [CW-1:0]            j;
    logic [CW-1:0]            pass;
    logic                     swapped;

    float_t                   cmp_a;
    float_t                   cmp_b;
    logic                     cmp_res;
    logic                     cmp_err;
    logic                     do_swap;
    logic                     pass_swapped;

    // The buffer is the result register. Because it resets to zero,
    // down_data also reads zero during reset.
    assign down_data = data_buf;

    // Select the adjacent pair at index j and index j+1 as comparator operands.
    always_comb begin
        cmp_a = data_buf[0];
        cmp_b = data_buf[1];
        for (int i = 0; i < N-1; i++) begin
            if (j == CW'(i)) begin
                cmp_a = data_buf[i];
                cmp_b = data_buf[i+1];
            end
        end
    end

    f_less_or_equal u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .res (cmp_res),
        .err (cmp_err)
    );

    // Swap only when the pair is strictly out of order, so equal values keep
    // their original order (the sort is stable). pass_swapped includes a swap
    // made on the current cycle, so the last compare of a pass counts toward
    // the early-exit decision.
    assign do_swap      = ~cmp_res;
    assign pass_swapped = swapped | do_swap;

    // Controller: handles load, one compare/swap step per cycle in SORT,
    // and holds the result in DONE until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_buf   <= '0;
            j          <= '0;
            pass       <= '0;
            swapped    <= 1'b0;
            up_ready   <= 1'b0;
            down_valid <= 1'b0;
            down_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    up_ready <= 1'b1;
                    if (up_valid && up_ready) begin
                        data_buf <= up_data;
                        j        <= '0;
                        pass     <= '0;
                        swapped  <= 1'b0;
                        up_ready <= 1'b0;
                        state    <= SORT;
                    end
                end

                SORT: begin
                    if (cmp_err) begin
                        down_err   <= 1'b1;
                        down_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (do_swap) begin
                            for (int i = 0; i < N-1; i++) begin
                                if (j == CW'(i)) begin
                                    data_buf[i]   <= cmp_b;
                                    data_buf[i+1] <= cmp_a;
                                end
                            end
                        end
                        if (j == LAST) begin
                            if ((pass == LAST) || ((EARLY_EXIT != 0) && !pass_swapped)) begin
                                down_valid <= 1'b1;
                                state      <= DONE;
                            end else begin
                                pass    <= pass + 1'b1;
                                j       <= '0;
                                swapped <= 1'b0;
                            end
                        end else begin
                            j       <= j + 1'b1;
                            swapped <= pass_swapped;
                        end
                    end
                end

                DONE: begin
                    if (down_ready) begin
                        down_valid <= 1'b0;
                        down_err   <= 1'b0;
                        up_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_floats_seq.sv
// Scoreboard testbench for sort_floats_seq.
// Two instances are used: one with early exit and one that always runs every pass.
module tb_sort_floats_seq;
    import sort_floats_seq_pkg::*;

    typedef logic [0:3][FLEN-1:0] vec_t;

    typedef struct {
        int   dut;
        vec_t data;
        logic err;
        int   cycle;
        int   load_edge;
    } exp_t;

    localparam logic [31:0] F_0   = 32'h00000000;
    localparam logic [31:0] F_05  = 32'h3F000000;
    localparam logic [31:0] F_1   = 32'h3F800000;
    localparam logic [31:0] F_2   = 32'h40000000;
    localparam logic [31:0] F_3   = 32'h40400000;
    localparam logic [31:0] F_4   = 32'h40800000;
    localparam logic [31:0] F_8   = 32'h41000000;
    localparam logic [31:0] F_M15 = 32'hBFC00000;
    localparam logic [31:0] F_M2  = 32'hC0000000;
    localparam logic [31:0] F_NAN = 32'h7FC00000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] up_valid;
    logic [1:0] up_ready;
    logic [1:0] down_valid;
    logic [1:0] down_ready;
    logic [1:0] down_err;
    vec_t       up_data0, up_data1, down_data0, down_data1;

    int   checks   = 0;
    int   failures = 0;
    int   cnt      = 0;
    exp_t q[$];
    exp_t cur[2];
    logic [1:0] vprev;
    logic [1:0] hs_prev;
    int   hs_count[2];

    sort_floats_seq #(.N(4), .EARLY_EXIT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid[0]),
        .up_ready   (up_ready[0]),
        .up_data    (up_data0),
        .down_valid (down_valid[0]),
        .down_ready (down_ready[0]),
        .down_data  (down_data0),
        .down_err   (down_err[0])
    );

    sort_floats_seq #(.N(4), .EARLY_EXIT(0)) dut_full (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid[1]),
        .up_ready   (up_ready[1]),
        .up_data    (up_data1),
        .down_valid (down_valid[1]),
        .down_ready (down_ready[1]),
        .down_data  (down_data1),
        .down_err   (down_err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Issue one vector and push the expected result into the scoreboard.
    task automatic apply_stimulus(input int d, input vec_t v, input vec_t exp_data,
                                  input logic exp_err, input int exp_cycle);
        exp_t it;
        int   waited = 0;
        @(negedge clk);
        up_valid[d] = 1'b1;
        if (d == 0) up_data0 = v; else up_data1 = v;
        while (!up_ready[d] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!up_ready[d]) begin
            report_fail("load_handshake");
            up_valid[d] = 1'b0;
            return;
        end
        it.dut       = d;
        it.data      = exp_data;
        it.err       = exp_err;
        it.cycle     = exp_cycle;
        it.load_edge = cnt + 1;
        q.push_back(it);
        @(negedge clk);
        up_valid[d] = 1'b0;
    endtask

    // Wait until the result handshake of instance d has happened.
    task automatic wait_done(input int d);
        int start = hs_count[d];
        int n = 0;
        while (hs_count[d] == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (hs_count[d] == start) report_fail("result_handshake");
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_up_ready"},   128'(up_ready[d]),   128'(0));
            check({tag, "_down_valid"}, 128'(down_valid[d]), 128'(0));
            check({tag, "_down_err"},   128'(down_err[d]),   128'(0));
            check({tag, "_down_data"},  (d == 0) ? down_data0 : down_data1, 128'(0));
        end
    endtask

    // Monitor: compare each new result against the scoreboard, confirm the
    // outputs stay stable while stalled, and confirm the return to IDLE.
    always begin
        vec_t dd;
        @(negedge clk);
        #1;
        if (rst) begin
            vprev   = '0;
            hs_prev = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                dd = (k == 0) ? down_data0 : down_data1;
                if (hs_prev[k]) begin
                    check("post_down_valid", 128'(down_valid[k]), 128'(0));
                    check("post_up_ready",   128'(up_ready[k]),   128'(1));
                    check("post_down_err",   128'(down_err[k]),   128'(0));
                end
                if (down_valid[k] && !vprev[k]) begin
                    if (q.size() == 0) begin
                        report_fail("unexpected_result");
                    end else begin
                        cur[k] = q.pop_front();
                        check("result_dut",  128'(k),   128'(cur[k].dut));
                        check("result_data", dd,          cur[k].data);
                        check("result_err",  128'(down_err[k]), 128'(cur[k].err));
                        check("result_cycle", 128'(cnt - cur[k].load_edge + 1), 128'(cur[k].cycle));
                    end
                end else if (down_valid[k] && vprev[k]) begin
                    check("hold_data",     dd,                  cur[k].data);
                    check("hold_err",      128'(down_err[k]), 128'(cur[k].err));
                    check("hold_up_ready", 128'(up_ready[k]), 128'(0));
                end
                hs_prev[k] = down_valid[k] && down_ready[k];
                if (hs_prev[k]) hs_count[k]++;
                vprev[k] = down_valid[k];
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        up_valid   = '0;
        down_ready = 2'b11;
        up_data0   = '0;
        up_data1   = '0;
        hs_count[0] = 0;
        hs_count[1] = 0;

        repeat (2) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] test 1: already sorted");
        apply_stimulus(0, {F_1, F_2, F_3, F_4}, {F_1, F_2, F_3, F_4}, 1'b0, 4);
        wait_done(0);

        $display("[TB] test 2: reversed");
        apply_stimulus(0, {F_4, F_3, F_2, F_1}, {F_1, F_2, F_3, F_4}, 1'b0, 10);
        wait_done(0);

        $display("[TB] test 3: full passes, sorted input");
        apply_stimulus(1, {F_1, F_2, F_3, F_4}, {F_1, F_2, F_3, F_4}, 1'b0, 10);
        wait_done(1);

        $display("[TB] test 4: duplicates and negatives");
        apply_stimulus(0, {F_2, F_M15, F_2, F_0}, {F_M15, F_0, F_2, F_2}, 1'b0, 10);
        wait_done(0);

        $display("[TB] test 5: NaN aborts");
        apply_stimulus(0, {F_1, F_NAN, F_05, F_3}, {F_1, F_NAN, F_05, F_3}, 1'b1, 2);
        wait_done(0);

        $display("[TB] test 6: backpressure");
        down_ready[0] = 1'b0;
        apply_stimulus(0, {F_3, F_M2, F_05, F_1}, {F_M2, F_05, F_1, F_3}, 1'b0, 7);
        waited = 0;
        while (!down_valid[0] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!down_valid[0]) report_fail("backpressure_valid");
        repeat (5) @(negedge clk);
        down_ready[0] = 1'b1;
        wait_done(0);
        apply_stimulus(0, {F_2, F_1, F_4, F_3}, {F_1, F_2, F_3, F_4}, 1'b0, 7);
        wait_done(0);

        $display("[TB] test 7: reset during sort");
        apply_stimulus(0, {F_4, F_3, F_2, F_1}, {F_1, F_2, F_3, F_4}, 1'b0, 10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("midsort_reset");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_up_ready", 128'(up_ready[0]), 128'(1));
        apply_stimulus(0, {F_05, F_M2, F_8, F_1}, {F_M2, F_05, F_1, F_8}, 1'b0, 7);
        wait_done(0);

        check("scoreboard_empty", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
